// File: rtl/line_tx_arbiter_if.sv
// rtl/line_tx_arbiter_if.sv - requester and transmitter signal bundle for line_tx_arbiter
// slave is the arbiter's view; master is the client/transmitter side.
interface line_tx_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]   i_req;
  logic [8*N_REQ-1:0] i_req_data;
  logic [2*N_REQ-1:0] i_req_mode;
  logic [N_REQ-1:0]   o_ack;
  logic [N_REQ-1:0]   o_err;
  logic [7:0]         o_tx_data;
  logic [1:0]         o_tx_mode;
  logic               o_tx_start_n;
  logic               i_tx_int;

  modport slave (
    input  i_req, i_req_data, i_req_mode, i_tx_int,
    output o_ack, o_err, o_tx_data, o_tx_mode, o_tx_start_n
  );

  modport master (
    output i_req, i_req_data, i_req_mode, i_tx_int,
    input  o_ack, o_err, o_tx_data, o_tx_mode, o_tx_start_n
  );
endinterface

// File: rtl/line_tx_arbiter.sv
// rtl/line_tx_arbiter.sv - round-robin arbiter sharing one line_tx transmitter
// Grants a requester, strobes the transmitter, then acks on its done edge or errors on timeout.
module line_tx_arbiter #(
  parameter int N_REQ     = 4,
  parameter int ID_W      = 2,
  parameter int START_LEN = 2,
  parameter int TIMEOUT   = 4095
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  line_tx_arbiter_if.slave bus,
  output logic            o_busy,
  output logic [ID_W-1:0] o_grant_id
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_WAIT,
    ST_DONE
  } state_t;

  localparam logic [ID_W:0]  NREQ_W    = (ID_W+1)'(N_REQ);
  localparam logic [15:0]    START_END = 16'(START_LEN - 1);
  localparam logic [15:0]    TMO_W     = 16'(TIMEOUT);
  localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

  state_t            state_q;
  logic [ID_W-1:0]   ptr_q;
  logic [ID_W-1:0]   grant_q;
  logic [15:0]       cnt_q;
  logic [15:0]       cnt_d;
  logic              int_q;
  logic [7:0]        tx_data_q;
  logic [1:0]        tx_mode_q;
  logic              start_n_q;
  logic [N_REQ-1:0]  ack_q;
  logic [N_REQ-1:0]  err_q;

  logic              pick_found;
  logic [ID_W-1:0]   pick_idx;
  logic [ID_W:0]     pick_sum;
  logic [7:0]        sel_data;
  logic [1:0]        sel_mode;
  logic              tx_rise;

  // Search ptr+1, ptr+2, ... with wrap so the last winner gets lowest priority.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    pick_sum   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      pick_sum = {1'b0, ptr_q} + (ID_W+1)'(k);
      if (pick_sum >= NREQ_W) begin
        pick_sum = pick_sum - NREQ_W;
      end
      if (!pick_found && bus.i_req[pick_sum[ID_W-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = pick_sum[ID_W-1:0];
      end
    end
  end

  always_comb begin
    sel_data = 8'h00;
    sel_mode = 2'b00;
    for (int k = 0; k < N_REQ; k++) begin
      if (pick_idx == ID_W'(k)) begin
        sel_data = bus.i_req_data[8*k +: 8];
        sel_mode = bus.i_req_mode[2*k +: 2];
      end
    end
  end

  assign cnt_d   = cnt_q + 16'd1;
  assign tx_rise = bus.i_tx_int & ~int_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      ptr_q     <= ID_W'(N_REQ - 1);
      grant_q   <= '0;
      cnt_q     <= '0;
      int_q     <= 1'b0;
      tx_data_q <= 8'h00;
      tx_mode_q <= 2'b00;
      start_n_q <= 1'b1;
      ack_q     <= '0;
      err_q     <= '0;
    end else begin
      // Sampled every cycle so a level already high when WAIT begins is not an edge.
      int_q <= bus.i_tx_int;
      case (state_q)
        ST_IDLE: begin
          if (pick_found) begin
            tx_data_q <= sel_data;
            tx_mode_q <= sel_mode;
            grant_q   <= pick_idx;
            state_q   <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          start_n_q <= 1'b0;
          cnt_q     <= '0;
          state_q   <= ST_START;
        end
        ST_START: begin
          if (cnt_q == START_END) begin
            start_n_q <= 1'b1;
            cnt_q     <= '0;
            state_q   <= ST_WAIT;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        ST_WAIT: begin
          cnt_q <= cnt_d;
          if (tx_rise) begin
            ack_q   <= ONE_HOT0 << grant_q;
            state_q <= ST_DONE;
          end else if (cnt_d == TMO_W) begin
            err_q   <= ONE_HOT0 << grant_q;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          ack_q   <= '0;
          err_q   <= '0;
          ptr_q   <= grant_q;
          cnt_q   <= '0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_busy           = (state_q != ST_IDLE);
  assign o_grant_id       = grant_q;
  assign bus.o_tx_data    = tx_data_q;
  assign bus.o_tx_mode    = tx_mode_q;
  assign bus.o_tx_start_n = start_n_q;
  assign bus.o_ack        = ack_q;
  assign bus.o_err        = err_q;

endmodule

// File: tb/tb_line_tx_arbiter.sv
// tb/tb_line_tx_arbiter.sv - directed self-checking bench for line_tx_arbiter
// Drives and samples on the falling clock edge; TIMEOUT is shortened to 20.
module tb_line_tx_arbiter;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       busy;
  logic [1:0] gid;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] data_tab [N];
  logic [1:0] mode_tab [N];

  line_tx_arbiter_if #(.N_REQ(N)) bus ();

  line_tx_arbiter #(
    .N_REQ(N), .ID_W(2), .START_LEN(2), .TIMEOUT(20)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .bus(bus.slave),
    .o_busy(busy),
    .o_grant_id(gid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.i_req = '0;
    bus.i_tx_int = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Returns on the first WAIT cycle, just after the strobe is released.
  task automatic wait_strobe(input int id);
    int n = 0;
    int low = 0;
    while (bus.o_tx_start_n !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("strobe_seen", 32'(n < 50), 32'd1);
    while (bus.o_tx_start_n === 1'b0 && low < 50) begin
      low++;
      @(negedge clk);
    end
    check("strobe_len", 32'(low), 32'd2);
    check("grant_id", 32'(gid), 32'(id));
    check("tx_data", 32'(bus.o_tx_data), 32'(data_tab[id]));
    check("tx_mode", 32'(bus.o_tx_mode), 32'(mode_tab[id]));
    check("busy_wait", 32'(busy), 32'd1);
  endtask

  task automatic pulse_int(input int delay);
    repeat (delay) @(negedge clk);
    bus.i_tx_int = 1'b1;
    @(negedge clk);
    bus.i_tx_int = 1'b0;
  endtask

  task automatic wait_done(input logic [3:0] exp_ack, input logic [3:0] exp_err,
                           input int exp_wait, input logic [3:0] drop);
    int n = 0;
    while (bus.o_ack == '0 && bus.o_err == '0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("ack", 32'(bus.o_ack), 32'(exp_ack));
    check("err", 32'(bus.o_err), 32'(exp_err));
    if (exp_wait >= 0) check("wait_cycles", 32'(n), 32'(exp_wait));
    bus.i_req = bus.i_req & ~drop;
    @(negedge clk);
    check("ack_pulse", 32'(bus.o_ack), 32'd0);
    check("err_pulse", 32'(bus.o_err), 32'd0);
    check("busy_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    logic seen;
    data_tab = '{8'h7D, 8'h5C, 8'h96, 8'hA3};
    mode_tab = '{2'b11, 2'b01, 2'b10, 2'b00};

    // 1: reset with random inputs
    rst_n = 1'b0;
    bus.i_req = 4'($urandom);
    bus.i_req_data = $urandom;
    bus.i_req_mode = 8'($urandom);
    bus.i_tx_int = 1'($urandom);
    repeat (3) @(negedge clk);
    check("rst_start_n", 32'(bus.o_tx_start_n), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ack", 32'(bus.o_ack), 32'd0);
    check("rst_err", 32'(bus.o_err), 32'd0);
    check("rst_gid", 32'(gid), 32'd0);
    check("rst_data", 32'(bus.o_tx_data), 32'd0);
    check("rst_mode", 32'(bus.o_tx_mode), 32'd0);
    for (int k = 0; k < N; k++) begin
      bus.i_req_data[8*k +: 8] = data_tab[k];
      bus.i_req_mode[2*k +: 2] = mode_tab[k];
    end
    do_reset();

    // 2: single request
    bus.i_req = 4'b0001;
    wait_strobe(0);
    pulse_int(10);
    wait_done(4'b0001, 4'b0000, -1, 4'b0001);

    // 3: round-robin, all held
    do_reset();
    bus.i_req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_strobe(i % 4);
      pulse_int(3);
      wait_done(4'(1 << (i % 4)), 4'b0000, -1, 4'b0000);
    end
    do_reset();
    bus.i_req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      wait_strobe(i);
      pulse_int(2);
      wait_done(4'(1 << i), 4'b0000, -1, (i == 3) ? 4'b1010 : 4'b0000);
    end
    wait_strobe(0);
    pulse_int(2);
    wait_done(4'b0001, 4'b0000, -1, 4'b0000);
    wait_strobe(2);
    pulse_int(2);
    wait_done(4'b0100, 4'b0000, -1, 4'b0101);

    // 4: timeout then next requester served
    do_reset();
    bus.i_req = 4'b0011;
    wait_strobe(0);
    wait_done(4'b0000, 4'b0001, 20, 4'b0001);
    wait_strobe(1);
    pulse_int(4);
    wait_done(4'b0010, 4'b0000, -1, 4'b0010);

    // 5: reset during WAIT
    do_reset();
    bus.i_req = 4'b0100;
    wait_strobe(2);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_start_n", 32'(bus.o_tx_start_n), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_gid", 32'(gid), 32'd0);
    @(negedge clk);
    check("midrst_ack", 32'(bus.o_ack), 32'd0);
    check("midrst_err", 32'(bus.o_err), 32'd0);
    rst_n = 1'b1;
    wait_strobe(2);
    pulse_int(2);
    wait_done(4'b0100, 4'b0000, -1, 4'b0100);

    // 6: spurious interrupt in IDLE, level high across WAIT entry
    do_reset();
    bus.i_tx_int = 1'b1;
    @(negedge clk);
    bus.i_tx_int = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("spur_idle_busy", 32'(busy), 32'd0);
    end
    bus.i_tx_int = 1'b1;
    bus.i_req = 4'b0010;
    wait_strobe(1);
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus.o_ack != '0 || bus.o_err != '0) seen = 1'b1;
    end
    check("no_early_done", 32'(seen), 32'd0);
    bus.i_tx_int = 1'b0;
    @(negedge clk);
    bus.i_tx_int = 1'b1;
    wait_done(4'b0010, 4'b0000, -1, 4'b0010);
    bus.i_tx_int = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
